// File: rtl/lsu_mem_port_if.sv
// Pipeline-side request/response and memory-side bus of the load/store port.
// The slave modport is the port's view; master is the surrounding environment.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_wdt;
  logic        req_sext;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wdt, req_sext,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wdt, req_sext,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port: aligns stores onto byte lanes, extracts and
// extends load data, flags misaligned accesses and memory response timeouts.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_port_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  wdt_q, wdt_d;
  logic        sext_q, sext_d;
  logic        err_q, err_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [63:0] data_q, data_d;

  logic        aligned;
  logic [7:0]  base_mask;
  logic [63:0] lane;
  logic [63:0] ext;
  logic        mem_valid;
  logic        resp_valid;

  always_comb begin
    aligned = 1'b1;
    case (bus.req_wdt)
      2'b01:   aligned = (bus.req_addr[0] == 1'b0);
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      2'b11:   aligned = (bus.req_addr[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wdt_d   = wdt_q;
    sext_d  = sext_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wen_d   = bus.req_wen;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wdt_d   = bus.req_wdt;
          sext_d  = bus.req_sext;
          err_d   = ~aligned;
          data_d  = '0;
          state_d = aligned ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 10'd1;
        // A completion in the final counted cycle takes priority over the timeout.
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q + 10'd1 == TO_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wdt_q   <= '0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wdt_q   <= wdt_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    lane = data_q >> {addr_q[2:0], 3'b000};
    case (wdt_q)
      2'b00:   ext = sext_q ? {{56{lane[7]}},  lane[7:0]}  : {56'd0, lane[7:0]};
      2'b01:   ext = sext_q ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
      2'b10:   ext = sext_q ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
      default: ext = lane;
    endcase
    case (wdt_q)
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign mem_valid  = (state_q == S_REQ);
  assign resp_valid = (state_q == S_RESP);

  assign bus.req_ready  = rst_n && (state_q == S_IDLE);
  assign bus.mem_valid  = mem_valid;
  assign bus.mem_wen    = mem_valid & wen_q;
  assign bus.mem_addr   = mem_valid ? {addr_q[63:3], 3'b000} : '0;
  assign bus.mem_wdata  = mem_valid ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign bus.mem_wmask  = mem_valid ? (base_mask << addr_q[2:0]) : '0;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_valid & err_q;
  assign bus.resp_rdata = (resp_valid && !err_q && !wen_q) ? ext : '0;

endmodule
